usb_bit_stuffer: RTL

Transmit-path bit stuffer for the USB serial engine. Sits directly downstream of the CRC5/CRC16 generators and the packet serializer: it consumes the serial packet stream (payload plus appended CRC bits) one bit per cycle and inserts a `0` after every run of six consecutive `1`s, as USB requires. While it inserts a stuff bit it stalls the upstream producer for one cycle. Its output feeds the NRZI encoder.

---
 rtl/usb_bit_stuffer_if.sv | 29 ++
 rtl/usb_bit_stuffer.sv | 81 ++++++++
 2 files changed

// File: rtl/usb_bit_stuffer_if.sv
// rtl/usb_bit_stuffer_if.sv - serial bit stream bundle between the packet serializer, the stuffer and the NRZI encoder
interface usb_bit_stuffer_if;
   logic s_in;
   logic bs_valid;
   logic bs_stall;
   logic bs_out;
   logic bs_out_valid;
   logic bs_done;

   // Stuffer side: consumes the packet bits, produces the line bits.
   modport slave (
      input  s_in,
      input  bs_valid,
      output bs_stall,
      output bs_out,
      output bs_out_valid,
      output bs_done
   );

   // Producer/observer side: drives packet bits, watches stall and the line output.
   modport master (
      output s_in,
      output bs_valid,
      input  bs_stall,
      input  bs_out,
      input  bs_out_valid,
      input  bs_done
   );
endinterface

// File: rtl/usb_bit_stuffer.sv
// rtl/usb_bit_stuffer.sv - USB transmit bit stuffer: inserts a 0 after every STUFF_LEN consecutive 1s
module usb_bit_stuffer #(
   parameter int STUFF_LEN = 6,
   parameter int CNT_W     = $clog2(STUFF_LEN + 1)
) (
   input  logic clk,
   input  logic rst_n,
   usb_bit_stuffer_if.slave bs
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      STUFF = 2'd2
   } state_t;

   // A 1 arriving while the counter already holds this value completes a run.
   localparam logic [CNT_W-1:0] LAST_ONE = CNT_W'(STUFF_LEN - 1);

   state_t           state;
   logic [CNT_W-1:0] ones_cnt;

   // State and run counter; the stuff cycle itself never consumes an upstream bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ones_cnt <= '0;
      end else begin
         case (state)
            IDLE, SEND: begin
               if (bs.bs_valid) begin
                  if (bs.s_in && (ones_cnt == LAST_ONE)) begin
                     state    <= STUFF;
                     ones_cnt <= '0;
                  end else if (bs.s_in) begin
                     state    <= SEND;
                     ones_cnt <= ones_cnt + CNT_W'(1);
                  end else begin
                     state    <= SEND;
                     ones_cnt <= '0;
                  end
               end else begin
                  // End of packet (from SEND) or still idle: either way, back to IDLE.
                  state    <= IDLE;
                  ones_cnt <= '0;
               end
            end
            STUFF: begin
               state    <= SEND;
               ones_cnt <= '0;
            end
            default: begin
               state    <= IDLE;
               ones_cnt <= '0;
            end
         endcase
      end
   end

   // Line outputs: zero-latency pass-through, overridden by the stuff bit during STUFF.
   always_comb begin
      bs.bs_out       = bs.s_in;
      bs.bs_out_valid = bs.bs_valid;
      bs.bs_stall     = 1'b0;
      bs.bs_done      = 1'b0;
      case (state)
         STUFF: begin
            bs.bs_out       = 1'b0;
            bs.bs_out_valid = 1'b1;
            bs.bs_stall     = 1'b1;
         end
         SEND: begin
            bs.bs_done = !bs.bs_valid;
         end
         default: begin
            bs.bs_done = 1'b0;
         end
      endcase
   end

endmodule
